// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the synchronous FIFO slice.
//   FIFO_DEPTH  default number of storage entries (power of two, >= 2)
//   FIFO_WIDTH  default data word width in bits
//   ptr_width() pointer width needed to address 'depth' entries
package fifo_pkg;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned FIFO_WIDTH = 8;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: request/response bundle of the synchronous FIFO.
//   wr_en_i, data_i     write request and write data
//   rd_en_i             read request
//   data_o, rd_valid_o  registered read data and its one-cycle valid flag
//   full_o, empty_o     occupancy flags
//   count_o             occupancy, 0..DEPTH
//   overflow_o          one-cycle pulse after a rejected write
//   underflow_o         one-cycle pulse after a rejected read
// master drives requests (user side); slave is the FIFO.
interface sync_fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = FIFO_WIDTH,
    parameter int unsigned ADDR_W = ptr_width(FIFO_DEPTH)
) ();

    logic              wr_en_i;
    logic [WIDTH-1:0]  data_i;
    logic              rd_en_i;
    logic [WIDTH-1:0]  data_o;
    logic              rd_valid_o;
    logic              full_o;
    logic              empty_o;
    logic [ADDR_W:0]   count_o;
    logic              overflow_o;
    logic              underflow_o;

    modport master (
        output wr_en_i, data_i, rd_en_i,
        input  data_o, rd_valid_o, full_o, empty_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  wr_en_i, data_i, rd_en_i,
        output data_o, rd_valid_o, full_o, empty_o, count_o, overflow_o, underflow_o
    );

endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: FIFO storage array.
//   clk                         single clock, rising edge
//   rst_i                       synchronous active-high reset (read register only)
//   wr_en_i/wr_addr_i/wr_data_i write port
//   rd_en_i/rd_addr_i           read port request
//   rd_data_o                   registered read data; holds when rd_en_i=0
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned WIDTH  = FIFO_WIDTH,
    parameter int unsigned ADDR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Array contents are never reset; the controller's pointers define what is live.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: synchronous FIFO controller with one-cycle registered reads.
//   clk    single clock, rising edge
//   rst_i  synchronous active-high reset; drops requests in the same cycle
//   bus    sync_fifo_ctrl_if.slave: write/read requests, read data + valid,
//          full/empty/count flags, overflow/underflow pulses
// Holds the read/write pointers, the occupancy counter, the flags and the
// fifo_mem storage instance.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned WIDTH  = FIFO_WIDTH,
    parameter int unsigned ADDR_W = ptr_width(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_i,
    sync_fifo_ctrl_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_valid_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              full;
    logic              empty;
    logic              wr_acc;
    logic              rd_acc;
    logic [WIDTH-1:0]  rd_data;

    // Flags come straight from the registered count, so they track count_o exactly.
    always_comb begin
        full     = (count_q == DEPTH_CNT);
        empty    = (count_q == '0);
        wr_acc   = bus.wr_en_i && !full  && !rst_i;
        rd_acc   = bus.rd_en_i && !empty && !rst_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are exactly ADDR_W bits, so the +1 wraps DEPTH-1 -> 0 for free.
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_acc;
            overflow_q  <= bus.wr_en_i && full;
            underflow_q <= bus.rd_en_i && empty;
        end
    end

    fifo_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .rst_i     (rst_i),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.data_i),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    assign bus.data_o      = rd_data;
    assign bus.rd_valid_o  = rd_valid_q;
    assign bus.full_o      = full;
    assign bus.empty_o     = empty;
    assign bus.count_o     = count_q;
    assign bus.overflow_o  = overflow_q;
    assign bus.underflow_o = underflow_q;

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of storage entries and SHALL be a power of two, at least 2.
REQ-002 Parameter WIDTH, default 8, SHALL set the data word width in bits.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH) = 3, SHALL set the pointer width.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_i  input  1  SHALL be a synchronous, active-high reset.
REQ-006 wr_en_i  input  1  SHALL be the write request.
REQ-007 data_i  input  WIDTH  SHALL be the write data, sampled with wr_en_i.
REQ-008 rd_en_i  input  1  SHALL be the read request.
REQ-009 data_o  output  WIDTH  SHALL be the registered read data.
REQ-010 rd_valid_o  output  1  SHALL mark data_o as new this cycle.
REQ-011 full_o  output  1  SHALL indicate that count equals DEPTH.
REQ-012 empty_o  output  1  SHALL indicate that count equals 0.
REQ-013 count_o  output  ADDR_W+1  SHALL give the current occupancy, 0..DEPTH.
REQ-014 overflow_o  output  1  SHALL pulse for one cycle when a write is rejected.
REQ-015 underflow_o  output  1  SHALL pulse for one cycle when a read is rejected.

Function
REQ-016 A write SHALL be accepted when wr_en_i=1 and full_o=0: the block stores data_i at wr_ptr, and wr_ptr advances by 1.
REQ-017 A read SHALL be accepted when rd_en_i=1 and empty_o=0: the block loads the word at rd_ptr into data_o on the same edge, and rd_ptr advances by 1.
REQ-018 Read latency SHALL be one cycle: rd_valid_o=1 in the cycle after the read request is accepted, and 0 otherwise.
REQ-019 data_o SHALL hold its last value when no read is accepted.
REQ-020 Pointers SHALL be ADDR_W bits and SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-021 count_o SHALL update per edge as follows: +1 on a write only, -1 on a read only, and unchanged on both or neither.
REQ-022 full_o and empty_o SHALL be registered or derived from count_o, and SHALL be valid in the same cycle as count_o.
REQ-023 Simultaneous read and write when 0 < count < DEPTH SHALL both be accepted, and count SHALL stay unchanged.
REQ-024 Simultaneous read and write when full SHALL accept the read, reject the write, and assert overflow_o.
REQ-025 Simultaneous read and write when empty SHALL accept the write, reject the read, and assert underflow_o; there is no fall-through, so data appears after a later read.
REQ-026 A rejected request SHALL NOT modify pointers, count, storage or data_o.
REQ-027 A read of the entry being written in the same cycle is impossible by construction (REQ-025) and SHALL never occur.

Reset
REQ-028 While rst_i=1 at a clock edge, the block SHALL set wr_ptr=0, rd_ptr=0, count_o=0, empty_o=1, full_o=0, data_o=0, rd_valid_o=0, overflow_o=0 and underflow_o=0.
REQ-029 Reset SHALL take priority over concurrent wr_en_i and rd_en_i, and requests in that cycle SHALL be dropped.
REQ-030 Reset mid-operation SHALL discard all stored entries logically; storage contents need not be cleared.

Structure
REQ-031 Storage SHALL be a separate sub-module, fifo_mem, with a write port (address, enable, data) and a registered read port (address, enable, data), both on clk.
REQ-032 sync_fifo_ctrl SHALL contain the pointers, occupancy counter, flag logic and the fifo_mem instance.
REQ-033 A shared package fifo_pkg SHALL hold the DEPTH and WIDTH defaults and a helper for the pointer width; no typedefs are required.

Verification
REQ-034 Reset, then 8 writes of 0x11..0x88 with no reads -> full_o=1 after the 8th edge, count_o=8; a 9th write -> overflow_o pulses once and count_o stays 8.
REQ-035 From full, 8 reads -> data_o = 0x11..0x88 in order, each with rd_valid_o one cycle after its request; then empty_o=1 and a further read -> underflow_o pulses and data_o holds 0x88.
REQ-036 Wrap test: write 5, read 5, write 6, read 6 -> pointers wrap past 7, order is preserved, and count_o ends at 0.
REQ-037 With count=3, simultaneous wr_en_i/rd_en_i for 10 cycles -> count_o stays 3, and data_o streams in write order with rd_valid_o continuously high.
REQ-038 Simultaneous read and write when full -> read returns the oldest word, overflow_o=1, count_o=7; when empty -> underflow_o=1 and count_o=1.
REQ-039 Assert rst_i with count=5 mid-stream -> the next cycle shows empty_o=1, count_o=0, rd_valid_o=0 and data_o=0.
